// File: rtl/led_fade_pkg.sv
// ============================================================================
//  Module   : led_fade_pkg
//  Purpose  : Shared definitions for the LED fade block: fade state encoding
//             and default values for the step divider and duty width.
//  Contents : fade_state_t, c_STEP_DIV, c_DUTY_W, c_PRESC_W
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package led_fade_pkg;

   // Fade controller states; the encoding is fixed so that other blocks in
   // the codebase can decode the state directly.
   typedef enum logic [1:0] {
      ST_LOW  = 2'b00,
      ST_RISE = 2'b01,
      ST_HIGH = 2'b10,
      ST_FALL = 2'b11
   } fade_state_t;

   localparam int unsigned c_STEP_DIV = 4096;  // clocks between duty steps
   localparam int unsigned c_DUTY_W   = 8;     // PWM counter / duty width
   localparam int unsigned c_PRESC_W  = 16;    // step prescaler width

endpackage : led_fade_pkg

`default_nettype wire

// File: rtl/led_fade_pwm.sv
// ============================================================================
//  Module   : led_pwm
//  Purpose  : Free-running PWM counter with a registered duty compare that
//             drives the LED.
//  Ports    : m_clock  - system clock
//             p_reset  - asynchronous active-low reset
//             i_duty   - current duty value
//             o_led    - registered PWM output
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_pwm
   import led_fade_pkg::*;
#(
   parameter int unsigned DUTY_W = c_DUTY_W
) (
   input  logic              m_clock,
   input  logic              p_reset,
   input  logic [DUTY_W-1:0] i_duty,
   output logic              o_led
);

   localparam logic [DUTY_W-1:0] c_DUTY_MAX = '1;

   logic [DUTY_W-1:0] r_pwm_cnt;
   logic              r_led;

   // The counter never stops: it ignores fade state and enable so the LED
   // keeps modulating while stepping is frozen.
   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         r_pwm_cnt <= '0;
         r_led     <= 1'b1;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         // Full duty is forced on explicitly; cnt < max alone would leave
         // one dark slot per period.
         r_led     <= (i_duty == c_DUTY_MAX) || (r_pwm_cnt < i_duty);
      end
   end

   assign o_led = r_led;

endmodule : led_pwm

`default_nettype wire

// File: rtl/led_fade.sv
// ============================================================================
//  Module   : led_fade
//  Purpose  : LED fade controller. Each change of the blink level starts a
//             linear fade of the PWM duty towards full on (blink=1) or off
//             (blink=0), one duty step every STEP_DIV clocks.
//  Ports    : m_clock - system clock
//             p_reset - asynchronous active-low reset
//             blink   - blink level, synchronous to m_clock
//             en      - fade enable (0 freezes stepping, PWM continues)
//             led     - PWM LED drive (registered)
//             duty    - current duty value
//             busy    - high while fading (RISE or FALL)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_fade
   import led_fade_pkg::*;
#(
   parameter int unsigned STEP_DIV = c_STEP_DIV,
   parameter int unsigned DUTY_W   = c_DUTY_W
) (
   input  logic              m_clock,
   input  logic              p_reset,
   input  logic              blink,
   input  logic              en,
   output logic              led,
   output logic [DUTY_W-1:0] duty,
   output logic              busy
);

   localparam logic [DUTY_W-1:0]    c_DUTY_MAX  = '1;
   localparam logic [c_PRESC_W-1:0] c_STEP_LAST = c_PRESC_W'(STEP_DIV - 1);

   fade_state_t          r_state;
   fade_state_t          w_state_nxt;
   logic [DUTY_W-1:0]    r_duty;
   logic [DUTY_W-1:0]    w_duty_nxt;
   logic [c_PRESC_W-1:0] r_presc;
   logic [c_PRESC_W-1:0] w_presc_nxt;
   logic                 r_blink_d;
   logic                 w_edge;
   logic                 w_take_edge;
   logic                 w_busy;

   assign w_edge = blink ^ r_blink_d;
   assign w_busy = (r_state == ST_RISE) || (r_state == ST_FALL);

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         r_state   <= ST_HIGH;
         r_duty    <= c_DUTY_MAX;
         r_presc   <= '0;
         r_blink_d <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_duty    <= w_duty_nxt;
         r_presc   <= w_presc_nxt;
         r_blink_d <= blink;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_presc_nxt = r_presc;
      w_take_edge = 1'b0;

      // Only edges that move the fade towards the new blink level count;
      // the duty is left where it is so a reversal has no jump.
      if (w_edge) begin
         case (r_state)
            ST_LOW:  w_take_edge = blink;
            ST_RISE: w_take_edge = !blink;
            ST_HIGH: w_take_edge = !blink;
            ST_FALL: w_take_edge = blink;
            default: w_take_edge = 1'b0;
         endcase
      end

      if (w_take_edge) begin
         // An accepted edge outranks a coincident step boundary.
         w_state_nxt = blink ? ST_RISE : ST_FALL;
         w_presc_nxt = '0;
      end else if (w_busy && en) begin
         if (r_presc == c_STEP_LAST) begin
            w_presc_nxt = '0;
            // Reaching an end stop finishes the fade instead of stepping.
            if (r_state == ST_RISE) begin
               if (r_duty == c_DUTY_MAX) w_state_nxt = ST_HIGH;
               else                      w_duty_nxt  = r_duty + 1'b1;
            end else begin
               if (r_duty == '0) w_state_nxt = ST_LOW;
               else              w_duty_nxt  = r_duty - 1'b1;
            end
         end else begin
            w_presc_nxt = r_presc + 1'b1;
         end
      end
   end

   led_pwm #(
      .DUTY_W (DUTY_W)
   ) u_pwm (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .i_duty  (r_duty),
      .o_led   (led)
   );

   assign duty = r_duty;
   assign busy = w_busy;

endmodule : led_fade

`default_nettype wire

// File: tb/tb_led_fade.sv
// ============================================================================
//  Module   : tb_led_fade
//  Purpose  : Self-checking bench for led_fade (STEP_DIV=4, DUTY_W=8).
//             Expected values are queued when stimulus is applied and
//             compared when the DUT output is sampled on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_fade;

   localparam int unsigned STEP_DIV = 4;
   localparam int unsigned DUTY_W   = 8;

   logic              m_clock = 1'b0;
   logic              p_reset;
   logic              blink;
   logic              en;
   logic              led;
   logic [DUTY_W-1:0] duty;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];

   led_fade #(
      .STEP_DIV (STEP_DIV),
      .DUTY_W   (DUTY_W)
   ) dut (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .blink   (blink),
      .en      (en),
      .led     (led),
      .duty    (duty),
      .busy    (busy)
   );

   always #5 m_clock = ~m_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_empty: got %0d, expected no output", obs);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge m_clock);
   endtask

   // Bounded wait for a duty value; an expired bound shows up as a mismatch.
   task automatic wait_duty(input logic [DUTY_W-1:0] target, input int limit, input string tag);
      int i;
      i = 0;
      while (duty !== target && i < limit) begin
         cyc(1);
         i++;
      end
      sb_push(tag, 32'(target));
      sb_pop(32'(duty));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      int cnt_a;
      int cnt_b;
      int cnt_c;
      int i;

      // ---------------- reset ------------------------------------------
      p_reset = 1'b0;
      blink   = 1'b1;
      en      = 1'b1;
      cyc(2);
      sb_push("rst_duty", 32'd255);
      sb_push("rst_led", 32'd1);
      sb_push("rst_busy", 32'd0);
      sb_push("rst_presc", 32'd0);
      sb_pop(32'(duty));
      sb_pop(32'(led));
      sb_pop(32'(busy));
      sb_pop(32'(dut.r_presc));
      p_reset = 1'b1;

      // ---------------- blink held high after reset --------------------
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      repeat (2000) begin
         cyc(1);
         if (led !== 1'b1)    cnt_a++;
         if (duty !== 8'd255) cnt_b++;
         if (busy !== 1'b0)   cnt_c++;
      end
      sb_push("hold_led_low_cycles", 32'd0);
      sb_push("hold_duty_bad_cycles", 32'd0);
      sb_push("hold_busy_cycles", 32'd0);
      sb_pop(32'(cnt_a));
      sb_pop(32'(cnt_b));
      sb_pop(32'(cnt_c));

      // ---------------- full fade down ---------------------------------
      blink = 1'b0;
      sb_push("fd_busy_after_edge", 32'd1);
      sb_push("fd_duty_after_edge", 32'd255);
      sb_push("fd_first_step", 32'd254);
      sb_push("fd_duty_zero", 32'd0);
      sb_push("fd_busy_at_zero", 32'd1);
      sb_push("fd_low_busy", 32'd0);
      sb_push("fd_low_duty", 32'd0);
      sb_push("fd_low_led_high_cycles", 32'd0);
      cyc(1);
      sb_pop(32'(busy));
      sb_pop(32'(duty));
      cyc(4);
      sb_pop(32'(duty));
      cyc(1016);
      sb_pop(32'(duty));
      sb_pop(32'(busy));
      cyc(4);
      sb_pop(32'(busy));
      sb_pop(32'(duty));
      cnt_a = 0;
      repeat (300) begin
         cyc(1);
         if (led !== 1'b0) cnt_a++;
      end
      sb_pop(32'(cnt_a));

      // ---------------- rise, then reverse at duty 100 -----------------
      blink = 1'b1;
      wait_duty(8'd100, 600, "rise_reach_100");
      blink = 1'b0;
      sb_push("rev_duty_no_jump", 32'd100);
      sb_push("rev_busy", 32'd1);
      sb_push("rev_duty_before_step", 32'd100);
      sb_push("rev_first_step", 32'd99);
      cyc(1);
      sb_pop(32'(duty));
      sb_pop(32'(busy));
      cyc(3);
      sb_pop(32'(duty));
      cyc(1);
      sb_pop(32'(duty));

      // ---------------- edge coincident with a step boundary -----------
      i = 0;
      while (dut.r_presc !== 16'd3 && i < 8) begin
         cyc(1);
         i++;
      end
      sb_push("co_presc_at_boundary", 32'd3);
      sb_pop(32'(dut.r_presc));
      blink = 1'b1;
      sb_push("co_duty_unchanged", 32'd99);
      sb_push("co_presc_cleared", 32'd0);
      sb_push("co_busy", 32'd1);
      sb_push("co_next_step", 32'd100);
      cyc(1);
      sb_pop(32'(duty));
      sb_pop(32'(dut.r_presc));
      sb_pop(32'(busy));
      cyc(4);
      sb_pop(32'(duty));

      // ---------------- en=0 hold at duty 64 mid-rise ------------------
      blink = 1'b0;
      wait_duty(8'd60, 300, "fall_reach_60");
      blink = 1'b1;
      wait_duty(8'd64, 100, "rise_reach_64");
      en = 1'b0;
      sb_push("en0_duty_hold", 32'd64);
      sb_push("en0_busy", 32'd1);
      sb_push("en0_led_high_per_256", 32'd64);
      sb_push("en0_duty_after_pwm", 32'd64);
      sb_push("en1_resume_step", 32'd65);
      cyc(50);
      sb_pop(32'(duty));
      sb_pop(32'(busy));
      cnt_a = 0;
      repeat (256) begin
         cyc(1);
         if (led === 1'b1) cnt_a++;
      end
      sb_pop(32'(cnt_a));
      sb_pop(32'(duty));
      en = 1'b1;
      cyc(4);
      sb_pop(32'(duty));

      // ---------------- reset mid-fall at duty 37 ----------------------
      blink = 1'b0;
      wait_duty(8'd37, 300, "fall_reach_37");
      p_reset = 1'b0;
      sb_push("arst_led", 32'd1);
      sb_push("arst_duty", 32'd255);
      sb_push("arst_busy", 32'd0);
      #1;
      sb_pop(32'(led));
      sb_pop(32'(duty));
      sb_pop(32'(busy));
      blink = 1'b1;
      cyc(3);
      p_reset = 1'b1;
      sb_push("post_rst_busy", 32'd0);
      sb_push("post_rst_duty", 32'd255);
      sb_push("post_rst_led", 32'd1);
      cyc(20);
      sb_pop(32'(busy));
      sb_pop(32'(duty));
      sb_pop(32'(led));

      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_leftover: got %0d pending, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_led_fade

`default_nettype wire
